scroll_latch: RTL and testbench

Scroll/priority latch stage directly downstream of the secondary-CPU address decoder. It consumes one layer-pair latch select (nLTH0 or nLTH1), nWE, ME, A[2:0] and D[7:0]. It holds CPU-written X/Y scroll, layer priority and ROM bank values. Scroll and priority are double-buffered and transferred to the tile generators at the start of vertical blank. The ROM bank value is applied immediately. Two instances are used per board: nLTH0 drives layers 0/1 plus ROM 9D bank; nLTH1 drives layers 2/3 plus ROM 12D bank.

---
 rtl/scroll_latch.sv | 162 ++++++++++++++++
 tb/tb_scroll_latch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scroll_latch.sv
// rtl/scroll_latch.sv - double-buffered scroll/priority latch with immediate ROM bank select
module scroll_latch #(
    parameter int DOUBLE_BUFFER = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       CLK_6M,
    input  logic       nRST,
    input  logic       nLTH,
    input  logic       nWE,
    input  logic       ME,
    input  logic [2:0] A,
    input  logic [7:0] D,
    input  logic       nVBLK,
    output logic [2:0] PRI0,
    output logic [8:0] XSCR0,
    output logic [7:0] YSCR0,
    output logic [2:0] PRI1,
    output logic [8:0] XSCR1,
    output logic [7:0] YSCR1,
    output logic [1:0] ROMBANK,
    output logic       UPDATE
);

    localparam bit DB = (DOUBLE_BUFFER != 0);

    logic                   wr;
    logic                   armed_q;
    logic                   wr_q;
    logic [2:0]             a_q;
    logic [7:0]             d_q;
    logic                   commit;
    logic                   scroll_commit;

    logic [2:0]             pri0_s_q,  pri0_s_d;
    logic [8:0]             xscr0_s_q, xscr0_s_d;
    logic [7:0]             yscr0_s_q, yscr0_s_d;
    logic [2:0]             pri1_s_q,  pri1_s_d;
    logic [8:0]             xscr1_s_q, xscr1_s_d;
    logic [7:0]             yscr1_s_q, yscr1_s_d;

    logic [2:0]             pri0_q,  pri1_q;
    logic [8:0]             xscr0_q, xscr1_q;
    logic [7:0]             yscr0_q, yscr1_q;
    logic [1:0]             bank_q,  bank_d;
    logic                   update_q, update_d;
    logic                   pending_q, pending_d;
    logic                   load;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   vblk_last_q;
    logic                   vbs;

    assign wr = ~nLTH & ~nWE & ME;

    // A strobe already high when reset releases never arms, so it cannot commit.
    assign commit        = wr_q & ~wr;
    assign scroll_commit = commit & (a_q[1:0] != 2'b11);
    assign vbs           = vblk_last_q & ~sync_q[SYNC_STAGES-1];

    always_comb begin
        pri0_s_d  = pri0_s_q;
        xscr0_s_d = xscr0_s_q;
        yscr0_s_d = yscr0_s_q;
        pri1_s_d  = pri1_s_q;
        xscr1_s_d = xscr1_s_q;
        yscr1_s_d = yscr1_s_q;
        bank_d    = bank_q;
        if (commit) begin
            case (a_q)
                3'd0: begin
                    pri0_s_d     = d_q[3:1];
                    xscr0_s_d[8] = d_q[0];
                end
                3'd1: xscr0_s_d[7:0] = d_q;
                3'd2: yscr0_s_d      = d_q;
                3'd3: bank_d         = d_q[1:0];
                3'd4: begin
                    pri1_s_d     = d_q[3:1];
                    xscr1_s_d[8] = d_q[0];
                end
                3'd5: xscr1_s_d[7:0] = d_q;
                3'd6: yscr1_s_d      = d_q;
                default: ;
            endcase
        end
    end

    // A commit landing on the vblank edge is folded straight into the transfer.
    always_comb begin
        load      = 1'b0;
        pending_d = 1'b0;
        if (DB) begin
            load      = vbs & (pending_q | scroll_commit);
            pending_d = vbs ? 1'b0 : (pending_q | scroll_commit);
        end else begin
            load      = scroll_commit;
        end
        update_d = load;
    end

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            armed_q     <= 1'b0;
            wr_q        <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            pri0_s_q    <= '0;
            xscr0_s_q   <= '0;
            yscr0_s_q   <= '0;
            pri1_s_q    <= '0;
            xscr1_s_q   <= '0;
            yscr1_s_q   <= '0;
            pri0_q      <= '0;
            xscr0_q     <= '0;
            yscr0_q     <= '0;
            pri1_q      <= '0;
            xscr1_q     <= '0;
            yscr1_q     <= '0;
            bank_q      <= '0;
            update_q    <= 1'b0;
            pending_q   <= 1'b0;
            sync_q      <= '1;
            vblk_last_q <= 1'b1;
        end else begin
            if (!wr) armed_q <= 1'b1;
            wr_q <= wr & armed_q;
            if (wr & armed_q) begin
                a_q <= A;
                d_q <= D;
            end
            pri0_s_q  <= pri0_s_d;
            xscr0_s_q <= xscr0_s_d;
            yscr0_s_q <= yscr0_s_d;
            pri1_s_q  <= pri1_s_d;
            xscr1_s_q <= xscr1_s_d;
            yscr1_s_q <= yscr1_s_d;
            bank_q    <= bank_d;
            if (load) begin
                pri0_q  <= pri0_s_d;
                xscr0_q <= xscr0_s_d;
                yscr0_q <= yscr0_s_d;
                pri1_q  <= pri1_s_d;
                xscr1_q <= xscr1_s_d;
                yscr1_q <= yscr1_s_d;
            end
            update_q    <= update_d;
            pending_q   <= pending_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], nVBLK};
            vblk_last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign PRI0    = pri0_q;
    assign XSCR0   = xscr0_q;
    assign YSCR0   = yscr0_q;
    assign PRI1    = pri1_q;
    assign XSCR1   = xscr1_q;
    assign YSCR1   = yscr1_q;
    assign ROMBANK = bank_q;
    assign UPDATE  = update_q;

endmodule

// File: tb/tb_scroll_latch.sv
// tb/tb_scroll_latch.sv - directed bench for scroll_latch in buffered and direct modes
module tb_scroll_latch;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       nlth = 1'b1;
    logic       nlth_b = 1'b1;
    logic       nwe = 1'b1;
    logic       me = 1'b0;
    logic [2:0] a = '0;
    logic [7:0] d = '0;
    logic       nvblk = 1'b1;

    logic [2:0] pri0, pri1, pri0_b, pri1_b;
    logic [8:0] xscr0, xscr1, xscr0_b, xscr1_b;
    logic [7:0] yscr0, yscr1, yscr0_b, yscr1_b;
    logic [1:0] rombank, rombank_b;
    logic       update, update_b;

    int errors = 0;
    int checks = 0;
    int ups, ups_b;

    always #5 clk = ~clk;

    scroll_latch #(.DOUBLE_BUFFER(1), .SYNC_STAGES(2)) dut (
        .CLK_6M(clk), .nRST(nrst), .nLTH(nlth), .nWE(nwe), .ME(me), .A(a), .D(d),
        .nVBLK(nvblk), .PRI0(pri0), .XSCR0(xscr0), .YSCR0(yscr0), .PRI1(pri1),
        .XSCR1(xscr1), .YSCR1(yscr1), .ROMBANK(rombank), .UPDATE(update)
    );

    scroll_latch #(.DOUBLE_BUFFER(0), .SYNC_STAGES(2)) dut_b (
        .CLK_6M(clk), .nRST(nrst), .nLTH(nlth_b), .nWE(nwe), .ME(me), .A(a), .D(d),
        .nVBLK(nvblk), .PRI0(pri0_b), .XSCR0(xscr0_b), .YSCR0(yscr0_b), .PRI1(pri1_b),
        .XSCR1(xscr1_b), .YSCR1(yscr1_b), .ROMBANK(rombank_b), .UPDATE(update_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_on(input logic [2:0] addr, input logic [7:0] data);
        a = addr; d = data; nlth = 1'b0; nwe = 1'b0; me = 1'b1;
    endtask

    task automatic strobe_off();
        nlth = 1'b1; nlth_b = 1'b1; nwe = 1'b1; me = 1'b0;
    endtask

    task automatic write(input logic [2:0] addr, input logic [7:0] data);
        strobe_on(addr, data);
        tick();
        strobe_off();
        tick();
    endtask

    // Full vblank pulse; counts UPDATE pulses of both instances.
    task automatic vblank(output int u, output int ub);
        u = 0; ub = 0;
        nvblk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            u += int'(update); ub += int'(update_b);
        end
        nvblk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            u += int'(update); ub += int'(update_b);
        end
    endtask

    initial begin
        tick(); tick();
        nrst = 1'b1;
        tick();
        chk("rst_pri0", 32'(pri0), 0);
        chk("rst_xscr0", 32'(xscr0), 0);
        chk("rst_yscr0", 32'(yscr0), 0);
        chk("rst_xscr1", 32'(xscr1), 0);
        chk("rst_rombank", 32'(rombank), 0);
        chk("rst_update", 32'(update), 0);

        write(3'd1, 8'h34);
        write(3'd0, 8'hA5);
        write(3'd2, 8'h7F);
        chk("buf_hold_xscr0", 32'(xscr0), 0);
        chk("buf_hold_pri0", 32'(pri0), 0);
        chk("buf_hold_update", 32'(update), 0);
        nvblk = 1'b0;
        tick(); tick();
        chk("buf_early_xscr0", 32'(xscr0), 0);
        chk("buf_early_update", 32'(update), 0);
        tick();
        chk("buf_xscr0", 32'(xscr0), 32'h134);
        chk("buf_pri0", 32'(pri0), 2);
        chk("buf_yscr0", 32'(yscr0), 32'h7F);
        chk("buf_update", 32'(update), 1);
        tick();
        chk("buf_update_drop", 32'(update), 0);
        nvblk = 1'b1;
        repeat (4) tick();

        write(3'd3, 8'hFE);
        chk("bank_immediate", 32'(rombank), 2);
        write(3'd7, 8'hFF);
        chk("off7_rombank", 32'(rombank), 2);
        chk("off7_xscr0", 32'(xscr0), 32'h134);
        vblank(ups, ups_b);
        chk("off7_no_update", 32'(ups), 0);

        strobe_on(3'd5, 8'h10);
        nlth_b = 1'b0;
        ups_b = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) d = 8'h22;
            tick();
            ups_b += int'(update_b);
        end
        strobe_off();
        for (int i = 0; i < 4; i++) begin
            tick();
            ups_b += int'(update_b);
        end
        chk("long_one_commit", 32'(ups_b), 1);
        chk("long_direct_xscr1", 32'(xscr1_b), 32'h022);
        chk("long_buffered_hold", 32'(xscr1), 0);
        vblank(ups, ups_b);
        chk("long_xscr1", 32'(xscr1), 32'h022);
        chk("long_update_once", 32'(ups), 1);

        nvblk = 1'b0;
        tick();
        strobe_on(3'd2, 8'h55);
        tick();
        strobe_off();
        tick();
        chk("coll_yscr0", 32'(yscr0), 32'h55);
        chk("coll_xscr0", 32'(xscr0), 32'h134);
        tick();
        nvblk = 1'b1;
        repeat (4) tick();
        vblank(ups, ups_b);
        chk("coll_pending_clear", 32'(ups), 0);

        a = 3'd6; d = 8'h9C; nlth_b = 1'b0; nwe = 1'b0; me = 1'b1;
        tick();
        chk("direct_pre", 32'(yscr1_b), 0);
        strobe_off();
        tick();
        chk("direct_yscr1", 32'(yscr1_b), 32'h9C);
        chk("direct_update", 32'(update_b), 1);
        chk("direct_yscr1_isolated", 32'(yscr1), 0);
        tick();
        chk("direct_update_drop", 32'(update_b), 0);
        vblank(ups, ups_b);
        chk("direct_vblank_no_update", 32'(ups_b), 0);

        strobe_on(3'd3, 8'h01);
        #3 nrst = 1'b0;
        #1;
        chk("arst_xscr0", 32'(xscr0), 0);
        chk("arst_pri0", 32'(pri0), 0);
        chk("arst_yscr0", 32'(yscr0), 0);
        chk("arst_xscr1", 32'(xscr1), 0);
        chk("arst_rombank", 32'(rombank), 0);
        chk("arst_direct_yscr1", 32'(yscr1_b), 0);
        chk("arst_update", 32'(update), 0);
        tick(); tick();
        nrst = 1'b1;
        tick(); tick();
        strobe_off();
        tick(); tick();
        chk("rst_strobe_discarded", 32'(rombank), 0);
        write(3'd3, 8'h01);
        chk("post_rst_bank", 32'(rombank), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
